// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: ALU opcodes, decoder mnemonics and the D->X control bundle.
package mips_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_NOR = 4'd5,
        ALU_SLT = 4'd6,
        ALU_SLL = 4'd7,
        ALU_SRL = 4'd8,
        ALU_LUI = 4'd9
    } t_alu_opcode;

    typedef enum logic [3:0] {
        NEM_ZERO = 4'd0,
        NEM_ADD  = 4'd1,
        NEM_SUB  = 4'd2,
        NEM_AND  = 4'd3,
        NEM_OR   = 4'd4,
        NEM_SLT  = 4'd5,
        NEM_ADDI = 4'd6,
        NEM_LW   = 4'd7,
        NEM_SW   = 4'd8,
        NEM_BEQ  = 4'd9,
        NEM_J    = 4'd10,
        NEM_LUI  = 4'd11
    } t_instr_pnmen;

    typedef struct packed {
        logic         reg_dst;
        logic         reg_write;
        logic         alu_src;
        logic         mem_write;
        logic         mem_read;
        logic         mem_to_reg;
        logic         branch;
        t_alu_opcode  alu_control;
        t_instr_pnmen instr_pnem;
    } t_idex_ctrl;

    // Control word of an inserted bubble: no architectural side effects.
    localparam t_idex_ctrl IDEX_BUBBLE = '{
        reg_dst:     1'b0,
        reg_write:   1'b0,
        alu_src:     1'b0,
        mem_write:   1'b0,
        mem_read:    1'b0,
        mem_to_reg:  1'b0,
        branch:      1'b0,
        alu_control: ALU_ADD,
        instr_pnem:  NEM_ZERO
    };

endpackage

// File: rtl/id_ex_stage_hazard_unit.sv
// Load-use and branch/jump squash detection for the D->X boundary.
// Squash outranks load-use: a stalled instruction that is being squashed need not be held.
module hazard_unit #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  i_mem_read_x,
    input  logic                  i_reg_write_x,
    input  logic [REG_ADDR_W-1:0] i_rt_x,
    input  logic [REG_ADDR_W-1:0] i_rs_d,
    input  logic [REG_ADDR_W-1:0] i_rt_d,
    input  logic                  i_beq_valid_x,
    input  logic                  i_jump_d,
    output logic                  o_stall_f,
    output logic                  o_stall_d,
    output logic                  o_flush_d,
    output logic                  o_insert_bubble
);

    logic w_load_use;
    logic w_squash;

    // $0 is hard-wired to zero, so a load targeting it never creates a dependency.
    assign w_load_use = i_mem_read_x & i_reg_write_x
                      & (i_rt_x != {REG_ADDR_W{1'b0}})
                      & ((i_rt_x == i_rs_d) | (i_rt_x == i_rt_d));
    assign w_squash   = i_beq_valid_x;

    // Priority resolution of squash over load-use, then plain jump flush.
    always_comb begin
        o_stall_f       = 1'b0;
        o_stall_d       = 1'b0;
        o_flush_d       = 1'b0;
        o_insert_bubble = 1'b0;
        if (w_squash) begin
            o_flush_d       = 1'b1;
            o_insert_bubble = 1'b1;
        end else if (w_load_use) begin
            o_stall_f       = 1'b1;
            o_stall_d       = 1'b1;
            o_insert_bubble = 1'b1;
        end else begin
            o_flush_d       = i_jump_d;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with load-use bubble insertion,
// branch/jump squash of the IF/ID register and saturating event counters.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RegDst_D,
    input  logic                  RegWrite_D,
    input  logic                  ALUSrc_D,
    input  t_alu_opcode           alu_control_D,
    input  logic                  MemWrite_D,
    input  logic                  MemRead_D,
    input  logic                  MemToReg_D,
    input  logic                  Branch_D,
    input  t_instr_pnmen          instr_pnem_D,
    input  logic [DATA_W-1:0]     rd1_D,
    input  logic [DATA_W-1:0]     rd2_D,
    input  logic [DATA_W-1:0]     imm_D,
    input  logic [DATA_W-1:0]     pc_plus4_D,
    input  logic [REG_ADDR_W-1:0] rs_D,
    input  logic [REG_ADDR_W-1:0] rt_D,
    input  logic [REG_ADDR_W-1:0] rd_D,
    input  logic                  BeqValid_X,
    input  logic                  Jump_D,
    output logic                  RegDst_X,
    output logic                  RegWrite_X,
    output logic                  ALUSrc_X,
    output t_alu_opcode           alu_control_X,
    output logic                  MemWrite_X,
    output logic                  MemRead_X,
    output logic                  MemToReg_X,
    output logic                  Branch_X,
    output t_instr_pnmen          instr_pnem_X,
    output logic [DATA_W-1:0]     rd1_X,
    output logic [DATA_W-1:0]     rd2_X,
    output logic [DATA_W-1:0]     imm_X,
    output logic [DATA_W-1:0]     pc_plus4_X,
    output logic [REG_ADDR_W-1:0] rs_X,
    output logic [REG_ADDR_W-1:0] rt_X,
    output logic [REG_ADDR_W-1:0] rd_X,
    output logic                  Jump_X,
    output logic [REG_ADDR_W-1:0] WriteReg_X,
    output logic                  valid_X,
    output logic                  stall_F,
    output logic                  stall_D,
    output logic                  flush_D,
    output logic [CNT_W-1:0]      bubble_cnt,
    output logic [CNT_W-1:0]      squash_cnt
);

    t_idex_ctrl            w_ctrl_d;
    t_idex_ctrl            r_ctrl_x;
    logic [REG_ADDR_W-1:0] w_write_reg_d;
    logic                  w_stall_f;
    logic                  w_stall_d;
    logic                  w_flush_d;
    logic                  w_insert_bubble;

    logic                  r_valid_x;
    logic                  r_jump_x;
    logic [DATA_W-1:0]     r_rd1_x;
    logic [DATA_W-1:0]     r_rd2_x;
    logic [DATA_W-1:0]     r_imm_x;
    logic [DATA_W-1:0]     r_pc_plus4_x;
    logic [REG_ADDR_W-1:0] r_rs_x;
    logic [REG_ADDR_W-1:0] r_rt_x;
    logic [REG_ADDR_W-1:0] r_rd_x;
    logic [REG_ADDR_W-1:0] r_write_reg_x;
    logic [CNT_W-1:0]      r_bubble_cnt;
    logic [CNT_W-1:0]      r_squash_cnt;

    assign w_ctrl_d = '{
        reg_dst:     RegDst_D,
        reg_write:   RegWrite_D,
        alu_src:     ALUSrc_D,
        mem_write:   MemWrite_D,
        mem_read:    MemRead_D,
        mem_to_reg:  MemToReg_D,
        branch:      Branch_D,
        alu_control: alu_control_D,
        instr_pnem:  instr_pnem_D
    };

    // Destination is resolved here so X sees it as a registered value.
    assign w_write_reg_d = RegDst_D ? rd_D : rt_D;

    hazard_unit #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard (
        .i_mem_read_x    (r_ctrl_x.mem_read),
        .i_reg_write_x   (r_ctrl_x.reg_write),
        .i_rt_x          (r_rt_x),
        .i_rs_d          (rs_D),
        .i_rt_d          (rt_D),
        .i_beq_valid_x   (BeqValid_X),
        .i_jump_d        (Jump_D),
        .o_stall_f       (w_stall_f),
        .o_stall_d       (w_stall_d),
        .o_flush_d       (w_flush_d),
        .o_insert_bubble (w_insert_bubble)
    );

    // D->X register bank: bubble on squash/load-use, otherwise capture decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl_x      <= IDEX_BUBBLE;
            r_valid_x     <= 1'b0;
            r_jump_x      <= 1'b0;
            r_rd1_x       <= {DATA_W{1'b0}};
            r_rd2_x       <= {DATA_W{1'b0}};
            r_imm_x       <= {DATA_W{1'b0}};
            r_pc_plus4_x  <= {DATA_W{1'b0}};
            r_rs_x        <= {REG_ADDR_W{1'b0}};
            r_rt_x        <= {REG_ADDR_W{1'b0}};
            r_rd_x        <= {REG_ADDR_W{1'b0}};
            r_write_reg_x <= {REG_ADDR_W{1'b0}};
        end else if (w_insert_bubble) begin
            r_ctrl_x      <= IDEX_BUBBLE;
            r_valid_x     <= 1'b0;
            r_jump_x      <= 1'b0;
            r_rd1_x       <= {DATA_W{1'b0}};
            r_rd2_x       <= {DATA_W{1'b0}};
            r_imm_x       <= {DATA_W{1'b0}};
            r_pc_plus4_x  <= {DATA_W{1'b0}};
            r_rs_x        <= {REG_ADDR_W{1'b0}};
            r_rt_x        <= {REG_ADDR_W{1'b0}};
            r_rd_x        <= {REG_ADDR_W{1'b0}};
            r_write_reg_x <= {REG_ADDR_W{1'b0}};
        end else begin
            r_ctrl_x      <= w_ctrl_d;
            r_valid_x     <= 1'b1;
            r_jump_x      <= Jump_D;
            r_rd1_x       <= rd1_D;
            r_rd2_x       <= rd2_D;
            r_imm_x       <= imm_D;
            r_pc_plus4_x  <= pc_plus4_D;
            r_rs_x        <= rs_D;
            r_rt_x        <= rt_D;
            r_rd_x        <= rd_D;
            r_write_reg_x <= w_write_reg_d;
        end
    end

    // Saturating event counters: a stall is one bubble, a flush is one squashed instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bubble_cnt <= {CNT_W{1'b0}};
            r_squash_cnt <= {CNT_W{1'b0}};
        end else begin
            if (w_stall_d && (r_bubble_cnt != {CNT_W{1'b1}})) begin
                r_bubble_cnt <= r_bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_bubble_cnt <= r_bubble_cnt;
            end
            if (w_flush_d && (r_squash_cnt != {CNT_W{1'b1}})) begin
                r_squash_cnt <= r_squash_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_squash_cnt <= r_squash_cnt;
            end
        end
    end

    assign RegDst_X      = r_ctrl_x.reg_dst;
    assign RegWrite_X    = r_ctrl_x.reg_write;
    assign ALUSrc_X      = r_ctrl_x.alu_src;
    assign alu_control_X = r_ctrl_x.alu_control;
    assign MemWrite_X    = r_ctrl_x.mem_write;
    assign MemRead_X     = r_ctrl_x.mem_read;
    assign MemToReg_X    = r_ctrl_x.mem_to_reg;
    assign Branch_X      = r_ctrl_x.branch;
    assign instr_pnem_X  = r_ctrl_x.instr_pnem;
    assign rd1_X         = r_rd1_x;
    assign rd2_X         = r_rd2_x;
    assign imm_X         = r_imm_x;
    assign pc_plus4_X    = r_pc_plus4_x;
    assign rs_X          = r_rs_x;
    assign rt_X          = r_rt_x;
    assign rd_X          = r_rd_x;
    assign Jump_X        = r_jump_x;
    assign WriteReg_X    = r_write_reg_x;
    assign valid_X       = r_valid_x;
    assign stall_F       = w_stall_f;
    assign stall_D       = w_stall_d;
    assign flush_D       = w_flush_d;
    assign bubble_cnt    = r_bubble_cnt;
    assign squash_cnt    = r_squash_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed plus randomized bench for id_ex_stage against an instruction-level model of the X slot.
module tb_id_ex_stage;
    import mips_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 2;
    localparam int CNT_MAX = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic RegDst_D, RegWrite_D, ALUSrc_D, MemWrite_D, MemRead_D, MemToReg_D, Branch_D;
    t_alu_opcode  alu_control_D;
    t_instr_pnmen instr_pnem_D;
    logic [DW-1:0] rd1_D, rd2_D, imm_D, pc_plus4_D;
    logic [AW-1:0] rs_D, rt_D, rd_D;
    logic BeqValid_X, Jump_D;

    logic RegDst_X, RegWrite_X, ALUSrc_X, MemWrite_X, MemRead_X, MemToReg_X, Branch_X, Jump_X;
    t_alu_opcode  alu_control_X;
    t_instr_pnmen instr_pnem_X;
    logic [DW-1:0] rd1_X, rd2_X, imm_X, pc_plus4_X;
    logic [AW-1:0] rs_X, rt_X, rd_X, WriteReg_X;
    logic valid_X, stall_F, stall_D, flush_D;
    logic [CW-1:0] bubble_cnt, squash_cnt;

    id_ex_stage #(.DATA_W(DW), .REG_ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .RegDst_D(RegDst_D), .RegWrite_D(RegWrite_D), .ALUSrc_D(ALUSrc_D),
        .alu_control_D(alu_control_D), .MemWrite_D(MemWrite_D), .MemRead_D(MemRead_D),
        .MemToReg_D(MemToReg_D), .Branch_D(Branch_D), .instr_pnem_D(instr_pnem_D),
        .rd1_D(rd1_D), .rd2_D(rd2_D), .imm_D(imm_D), .pc_plus4_D(pc_plus4_D),
        .rs_D(rs_D), .rt_D(rt_D), .rd_D(rd_D), .BeqValid_X(BeqValid_X), .Jump_D(Jump_D),
        .RegDst_X(RegDst_X), .RegWrite_X(RegWrite_X), .ALUSrc_X(ALUSrc_X),
        .alu_control_X(alu_control_X), .MemWrite_X(MemWrite_X), .MemRead_X(MemRead_X),
        .MemToReg_X(MemToReg_X), .Branch_X(Branch_X), .instr_pnem_X(instr_pnem_X),
        .rd1_X(rd1_X), .rd2_X(rd2_X), .imm_X(imm_X), .pc_plus4_X(pc_plus4_X),
        .rs_X(rs_X), .rt_X(rt_X), .rd_X(rd_X), .Jump_X(Jump_X), .WriteReg_X(WriteReg_X),
        .valid_X(valid_X), .stall_F(stall_F), .stall_D(stall_D), .flush_D(flush_D),
        .bubble_cnt(bubble_cnt), .squash_cnt(squash_cnt)
    );

    // Model of whatever instruction currently occupies X.
    typedef struct {
        logic valid, rdst, rwr, asrc, mwr, mrd, m2r, br, jmp;
        logic [3:0] alu, nem;
        logic [DW-1:0] rd1, rd2, imm, pc;
        logic [AW-1:0] rs, rt, rd, wr;
    } x_t;

    x_t mx;
    int m_bub, m_sq;
    int n_vec, n_err;

    function automatic x_t bubble();
        x_t b;
        b = '{default: '0};
        b.alu = ALU_ADD;
        b.nem = NEM_ZERO;
        return b;
    endfunction

    function automatic int sat(input int v);
        return (v < CNT_MAX) ? v + 1 : v;
    endfunction

    function logic exp_load_use();
        return mx.valid && mx.mrd && mx.rwr && (mx.rt != 5'd0) && (mx.rt == rs_D || mx.rt == rt_D);
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_haz();
        logic lu, st, fl;
        lu = exp_load_use();
        st = lu && !BeqValid_X;
        fl = BeqValid_X || (!lu && Jump_D);
        check("haz", 128'({stall_F, stall_D, flush_D}), 128'({st, st, fl}));
    endtask

    task automatic check_x();
        check("ctrl", 128'({valid_X, RegDst_X, RegWrite_X, ALUSrc_X, MemWrite_X, MemRead_X,
                            MemToReg_X, Branch_X, Jump_X}),
                      128'({mx.valid, mx.rdst, mx.rwr, mx.asrc, mx.mwr, mx.mrd, mx.m2r, mx.br, mx.jmp}));
        check("op", 128'({alu_control_X, instr_pnem_X}), 128'({mx.alu, mx.nem}));
        check("data", {rd1_X, rd2_X, imm_X, pc_plus4_X}, {mx.rd1, mx.rd2, mx.imm, mx.pc});
        check("idx", 128'({rs_X, rt_X, rd_X, WriteReg_X}), 128'({mx.rs, mx.rt, mx.rd, mx.wr}));
        check("cnt", 128'({bubble_cnt, squash_cnt}), 128'({2'(m_bub), 2'(m_sq)}));
    endtask

    // What the edge does to X: squash beats load-use beats normal issue.
    task automatic model_edge();
        logic lu;
        lu = exp_load_use();
        if (BeqValid_X) begin
            mx = bubble();
            m_sq = sat(m_sq);
        end else if (lu) begin
            mx = bubble();
            m_bub = sat(m_bub);
        end else begin
            mx.valid = 1'b1;
            mx.rdst = RegDst_D; mx.rwr = RegWrite_D; mx.asrc = ALUSrc_D; mx.mwr = MemWrite_D;
            mx.mrd = MemRead_D; mx.m2r = MemToReg_D; mx.br = Branch_D; mx.jmp = Jump_D;
            mx.alu = alu_control_D; mx.nem = instr_pnem_D;
            mx.rd1 = rd1_D; mx.rd2 = rd2_D; mx.imm = imm_D; mx.pc = pc_plus4_D;
            mx.rs = rs_D; mx.rt = rt_D; mx.rd = rd_D;
            mx.wr = RegDst_D ? rd_D : rt_D;
            if (Jump_D) m_sq = sat(m_sq);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_haz();
        model_edge();
        @(posedge clk);
        #1;
        check_x();
    endtask

    // kind: 0 nop, 1 add, 2 sub, 3 lw, 4 sw, 5 beq, 6 j, 7 addi
    task automatic set_instr(input int kind, input int rs, input int rt, input int rd);
        RegDst_D = 1'b0; RegWrite_D = 1'b0; ALUSrc_D = 1'b0; MemWrite_D = 1'b0;
        MemRead_D = 1'b0; MemToReg_D = 1'b0; Branch_D = 1'b0; Jump_D = 1'b0;
        alu_control_D = ALU_ADD; instr_pnem_D = NEM_ZERO;
        rs_D = 5'(rs); rt_D = 5'(rt); rd_D = 5'(rd);
        rd1_D = $urandom; rd2_D = $urandom; imm_D = $urandom; pc_plus4_D = $urandom;
        case (kind)
            1: begin RegDst_D = 1'b1; RegWrite_D = 1'b1; instr_pnem_D = NEM_ADD; end
            2: begin RegDst_D = 1'b1; RegWrite_D = 1'b1; alu_control_D = ALU_SUB; instr_pnem_D = NEM_SUB; end
            3: begin RegWrite_D = 1'b1; ALUSrc_D = 1'b1; MemRead_D = 1'b1; MemToReg_D = 1'b1; instr_pnem_D = NEM_LW; end
            4: begin ALUSrc_D = 1'b1; MemWrite_D = 1'b1; instr_pnem_D = NEM_SW; end
            5: begin Branch_D = 1'b1; alu_control_D = ALU_SUB; instr_pnem_D = NEM_BEQ; end
            6: begin Jump_D = 1'b1; instr_pnem_D = NEM_J; end
            7: begin RegWrite_D = 1'b1; ALUSrc_D = 1'b1; instr_pnem_D = NEM_ADDI; end
            default: begin
                rs_D = 5'd0; rt_D = 5'd0; rd_D = 5'd0;
                rd1_D = 32'd0; rd2_D = 32'd0; imm_D = 32'd0; pc_plus4_D = 32'd0;
            end
        endcase
    endtask

    // Asynchronous reset pulse placed between edges, with checks before and during it.
    task automatic do_reset();
        #1;
        check_haz();
        rst = 1'b1;
        #1;
        mx = bubble();
        m_bub = 0;
        m_sq = 0;
        check_x();
        check("rst_haz", 128'({stall_F, stall_D, flush_D}), 128'(3'b000));
        #1;
        rst = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        m_bub = 0; m_sq = 0;
        mx = bubble();
        rst = 1'b1;
        BeqValid_X = 1'b0;
        set_instr(0, 0, 0, 0);
        #3;
        check_x();
        check_haz();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Load-use on $t0: one bubble, then the ADD issues.
        set_instr(3, 1, 8, 0); tick();
        set_instr(1, 8, 2, 3); tick();
        check("lu_bub", 128'({valid_X, bubble_cnt}), 128'({1'b0, 2'd1}));
        tick();
        check("lu_issue", 128'({valid_X, instr_pnem_X}), 128'({1'b1, NEM_ADD}));

        // Load into $0 never creates a dependency.
        set_instr(3, 1, 0, 0); tick();
        set_instr(1, 0, 0, 4); tick();

        // Taken branch squashes a load sitting in D.
        set_instr(3, 2, 6, 0); BeqValid_X = 1'b1; tick();
        BeqValid_X = 1'b0;
        check("br_sq", 128'({MemRead_X, valid_X, squash_cnt}), 128'({1'b0, 1'b0, 2'd1}));

        // Squash and load-use together: squash wins, no stall.
        set_instr(3, 1, 9, 0); tick();
        set_instr(1, 9, 3, 5); BeqValid_X = 1'b1; tick();
        BeqValid_X = 1'b0;

        // Jump is captured and flushes IF/ID.
        set_instr(6, 0, 0, 0); tick();
        check("jmp", 128'({valid_X, Jump_X}), 128'({1'b1, 1'b1}));

        // Drive both counters into saturation.
        for (int k = 0; k < 5; k++) begin
            set_instr(2, 1, 2, 3); BeqValid_X = 1'b1; tick();
        end
        BeqValid_X = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_instr(3, 1, 5, 0); tick();
            set_instr(1, 5, 1, 7); tick();
            tick();
        end
        check("sat", 128'({bubble_cnt, squash_cnt}), 128'({2'd3, 2'd3}));

        // Reset while a load-use stall is being asserted.
        set_instr(3, 1, 8, 0); tick();
        set_instr(1, 8, 2, 3);
        do_reset();
        tick();

        for (int i = 0; i < 300; i++) begin
            if (i == 150) begin
                set_instr(0, 0, 0, 0);
                BeqValid_X = 1'b0;
                do_reset();
            end
            set_instr(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            BeqValid_X = ($urandom_range(0, 7) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
